// File: rtl/ts_multi_generator.sv
// Multi-PID MPEG-TS test stream generator: round-robin packets for N_CH PIDs on one
// parallel TS port, with per-PID continuity counters, optional stuffing and idle gaps.
module ts_multi_generator #(
    parameter int N_CH      = 4,
    parameter int PKT_LEN   = 188,
    parameter int GAP_SLOTS = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [12:0] PID_BASE,
    input  logic        ENABLE,
    output logic [7:0]  DATA,
    output logic        D_CLK,
    output logic        D_VALID,
    output logic        P_SYNC
);

    localparam int               CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [7:0]       GAP_LAST  = (GAP_SLOTS > 0) ? 8'(GAP_SLOTS - 1) : 8'd0;
    localparam bit               HAS_STUFF = (PKT_LEN == 204);
    localparam bit               HAS_GAP   = (GAP_SLOTS > 0);

    if (!(PKT_LEN == 188 || PKT_LEN == 204) || N_CH < 1 || N_CH > 16 ||
        GAP_SLOTS < 0 || GAP_SLOTS > 255) begin : g_param_check
        $error("ts_multi_generator: illegal PKT_LEN, N_CH or GAP_SLOTS");
    end

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_STUFF, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [3:0]      cc_q [N_CH];
    logic [3:0]      cc_d [N_CH];
    logic [12:0]     pid_q, pid_d;
    logic            dclk_q, dclk_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            sync_q, sync_d;
    logic            slot_s;
    logic            pkt_end_s;

    // A slot edge is the CLK edge that takes D_CLK from 1 to 0
    assign slot_s = dclk_q;
    assign dclk_d = ~dclk_q;

    // State register and all datapath flops
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            ch_q    <= '0;
            cc_q    <= '{default: 4'd0};
            pid_q   <= 13'd0;
            dclk_q  <= 1'b0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            cc_q    <= cc_d;
            pid_q   <= pid_d;
            dclk_q  <= dclk_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
        end
    end

    // Next-state and slot counter; flags the last slot of a packet (incl. stuffing/gap)
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pkt_end_s = 1'b0;
        if (slot_s) begin
            case (state_q)
                S_IDLE: begin
                    if (ENABLE) begin
                        state_d = S_SEND;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_SEND: begin
                    if (cnt_q == 8'd187) begin
                        cnt_d = 8'd0;
                        if (HAS_STUFF) begin
                            state_d = S_STUFF;
                        end else if (HAS_GAP) begin
                            state_d = S_GAP;
                        end else begin
                            state_d   = S_IDLE;
                            pkt_end_s = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_STUFF: begin
                    if (cnt_q == 8'd15) begin
                        cnt_d = 8'd0;
                        if (HAS_GAP) begin
                            state_d = S_GAP;
                        end else begin
                            state_d   = S_IDLE;
                            pkt_end_s = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d     = 8'd0;
                        state_d   = S_IDLE;
                        pkt_end_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // PID latched at packet start; channel rotation and CC advance at packet end
    always_comb begin
        ch_d  = ch_q;
        cc_d  = cc_q;
        pid_d = pid_q;
        if (slot_s && state_q == S_IDLE && ENABLE) begin
            pid_d = PID_BASE + 13'(ch_q);
        end else begin
            pid_d = pid_q;
        end
        if (pkt_end_s) begin
            cc_d[ch_q] = cc_q[ch_q] + 4'd1;
            ch_d       = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
        end else begin
            ch_d = ch_q;
        end
    end

    // Output byte for the slot being launched
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        sync_d  = sync_q;
        if (slot_s) begin
            data_d  = 8'd0;
            valid_d = 1'b0;
            sync_d  = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ENABLE) begin
                        data_d  = 8'h47;
                        valid_d = 1'b1;
                        sync_d  = 1'b1;
                    end else begin
                        data_d = 8'd0;
                    end
                end
                S_SEND: begin
                    valid_d = 1'b1;
                    case (cnt_q)
                        8'd1:    data_d = {3'b010, pid_q[12:8]};
                        8'd2:    data_d = pid_q[7:0];
                        8'd3:    data_d = {4'b0001, cc_q[ch_q]};
                        default: data_d = cnt_q - 8'd4;
                    endcase
                end
                default: begin
                    data_d = 8'd0;
                end
            endcase
        end else begin
            data_d = data_q;
        end
    end

    assign DATA    = data_q;
    assign D_CLK   = dclk_q;
    assign D_VALID = valid_q;
    assign P_SYNC  = sync_q;

endmodule

// File: tb/tb_ts_multi_generator.sv
// Bench for ts_multi_generator: three configurations driven with random ENABLE/PID_BASE,
// every slot compared against a packet-level reference model.
module tb_ts_multi_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en     [3];
    logic [12:0] base   [3];
    logic [7:0]  data_w [3];
    logic        dclk_w [3];
    logic        valid_w[3];
    logic        sync_w [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ts_multi_generator #(.N_CH(4), .PKT_LEN(188), .GAP_SLOTS(0)) dut_a (
        .CLK(clk), .RST(rst_n), .PID_BASE(base[0]), .ENABLE(en[0]),
        .DATA(data_w[0]), .D_CLK(dclk_w[0]), .D_VALID(valid_w[0]), .P_SYNC(sync_w[0]));
    ts_multi_generator #(.N_CH(1), .PKT_LEN(188), .GAP_SLOTS(0)) dut_b (
        .CLK(clk), .RST(rst_n), .PID_BASE(base[1]), .ENABLE(en[1]),
        .DATA(data_w[1]), .D_CLK(dclk_w[1]), .D_VALID(valid_w[1]), .P_SYNC(sync_w[1]));
    ts_multi_generator #(.N_CH(3), .PKT_LEN(204), .GAP_SLOTS(3)) dut_c (
        .CLK(clk), .RST(rst_n), .PID_BASE(base[2]), .ENABLE(en[2]),
        .DATA(data_w[2]), .D_CLK(dclk_w[2]), .D_VALID(valid_w[2]), .P_SYNC(sync_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: per DUT, packet in progress, slot index within it, per-channel CC
    int          nch [3] = '{4, 1, 3};
    int          tot [3] = '{188, 188, 207};
    bit          act [3];
    int          idx [3];
    int          mch [3];
    logic [12:0] ppid[3];
    logic [3:0]  mcc [3][16];
    logic        exp_dclk;
    logic [7:0]  cap1[3];
    logic [7:0]  cap2[3];
    bit          log_on = 1'b0;
    logic [23:0] a_log[$];
    logic [7:0]  b_log[$];

    task automatic model_slot(input int d);
        logic [7:0] exp_b;
        logic       ev;
        logic       es;
        exp_b = 8'd0;
        ev    = 1'b0;
        es    = 1'b0;
        if (!act[d] && en[d]) begin
            act[d]  = 1'b1;
            idx[d]  = 0;
            ppid[d] = base[d] + 13'(mch[d]);
        end
        if (act[d]) begin
            if (idx[d] < 188) begin
                ev = 1'b1;
                case (idx[d])
                    0:       begin exp_b = 8'h47; es = 1'b1; end
                    1:       exp_b = {3'b010, ppid[d][12:8]};
                    2:       exp_b = ppid[d][7:0];
                    3:       exp_b = {4'h1, mcc[d][mch[d]]};
                    default: exp_b = 8'(idx[d] - 4);
                endcase
            end
            if (idx[d] == 1) cap1[d] = data_w[d];
            if (idx[d] == 2) cap2[d] = data_w[d];
            if (idx[d] == 3 && log_on) begin
                if (d == 0) a_log.push_back({cap1[d], cap2[d], data_w[d]});
                if (d == 1) b_log.push_back(data_w[d]);
            end
            idx[d]++;
            if (idx[d] == tot[d]) begin
                act[d]         = 1'b0;
                mcc[d][mch[d]] = mcc[d][mch[d]] + 4'd1;
                mch[d]         = (mch[d] + 1) % nch[d];
            end
        end
        chk($sformatf("slot_d%0d", d), {23'd0, valid_w[d], sync_w[d], data_w[d]},
            {23'd0, ev, es, exp_b});
    endtask

    // Monitor: inputs only change at negedge+1, so values seen here are those of the last posedge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_dclk = 1'b0;
                for (int d = 0; d < 3; d++) begin
                    act[d] = 1'b0;
                    idx[d] = 0;
                    mch[d] = 0;
                    for (int k = 0; k < 16; k++) mcc[d][k] = 4'd0;
                end
            end else begin
                exp_dclk = ~exp_dclk;
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("dclk_d%0d", d), {31'd0, dclk_w[d]}, {31'd0, exp_dclk});
                    if (!exp_dclk) model_slot(d);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) en[d] = 1'b0;
        base[0] = 13'h1000;
        base[1] = 13'h1000;
        base[2] = 13'h1FFE;
        repeat (3) @(negedge clk);
        chk("reset_outs", {21'd0, dclk_w[0], valid_w[0], sync_w[0], data_w[0]}, 32'd0);
        #1;
        for (int d = 0; d < 3; d++) en[d] = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("first_sync", {23'd0, valid_w[0], sync_w[0], data_w[0]}, {23'd0, 1'b1, 1'b1, 8'h47});

        // Reset in the middle of traffic
        repeat (500) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("async_rst_d%0d", d),
                {21'd0, dclk_w[d], valid_w[d], sync_w[d], data_w[d]}, 32'd0);
        end
        repeat (3) @(negedge clk);
        #1;
        rst_n  = 1'b1;
        log_on = 1'b1;

        // Continuous traffic: PID rotation and CC wrap
        repeat (17 * 188 * 2 + 200) @(negedge clk);
        log_on = 1'b0;
        chk("a_log_size", {31'd0, a_log.size() >= 8}, 32'd1);
        chk("b_log_size", {31'd0, b_log.size() >= 17}, 32'd1);
        for (int k = 0; k < 8 && k < a_log.size(); k++) begin
            chk($sformatf("a_hdr_%0d", k), {8'd0, a_log[k]},
                {8'd0, 8'h50, 8'(k % 4), 8'(16 + k / 4)});
        end
        for (int k = 0; k < 17 && k < b_log.size(); k++) begin
            chk($sformatf("b_cc_%0d", k), {24'd0, b_log[k]}, {24'd0, 8'(16 + k % 16)});
        end

        // Random ENABLE toggles and PID_BASE changes at arbitrary slots
        for (int c = 0; c < 24000; c++) begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(0, 399) == 0) en[d] = ~en[d];
                if ($urandom_range(0, 599) == 0) base[d] = 13'($urandom);
            end
        end
        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
